// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: add/sub/and/or in one cycle, sll/slli one bit per cycle.
// Latency: done in the cycle after edge k+N (N = shift amount, 0 for non-shift ops).
// Backpressure: start is ignored while busy; the caller stalls on busy and waits for done.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              request, accepted in IDLE or DONE
//   alu_ctrl [3:0]     0010 add, 0110 sub, 0000 and, 0001 or, 0100 sll
//   a, b [WIDTH-1:0]   operands; b[SHAMT_W-1:0] is the shift amount
//   result, zero       registered result and (result == 0)
//   busy               high while a shift is in progress
//   done               one-cycle pulse, result/zero/illegal valid
//   illegal            alu_ctrl was not a recognised code
module alu_seq_exec #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   op_res;
  logic               op_ill;
  logic               op_shift;
  logic [WIDTH-1:0]   shifted;

  assign shamt   = b[SHAMT_W-1:0];
  assign shifted = {acc[WIDTH-2:0], 1'b0};

  // Single-cycle result. Any code outside the five listed ones (including an
  // undriven/unknown decode) falls to the default arm, so X never reaches state.
  always_comb begin
    op_res   = '0;
    op_ill   = 1'b0;
    op_shift = 1'b0;
    case (alu_ctrl)
      OP_ADD:  op_res = a + b;
      OP_SUB:  op_res = a - b;
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_SLL: begin
        // shamt==0 completes immediately with result = a
        op_res   = a;
        op_shift = (shamt != '0);
      end
      default: op_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (op_shift) begin
              acc   <= a;
              cnt   <= shamt;
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              result  <= op_res;
              zero    <= (op_res == '0);
              illegal <= op_ill;
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            // result/zero/illegal hold after the done pulse
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          // start is ignored here; operands are not captured
          acc <= shifted;
          cnt <= cnt - 1'b1;
          if (cnt == 1) begin
            result  <= shifted;
            zero    <= (shifted == '0);
            illegal <= 1'b0;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: scoreboard of expected results, latency and busy checks.
// Latency: n/a (testbench).
// Backpressure: drives start only when the DUT can accept, except where ignore behaviour is tested.
module tb_alu_seq_exec;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SLL = 4'b0100;
  localparam logic [3:0] C_SUB = 4'b0110;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
    logic        il;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal;

  int   asserts;
  int   failures;
  exp_t sb_q[$];
  exp_t sb_e;

  alu_seq_exec #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .result(result), .zero(zero), .busy(busy),
    .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] c, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    e.il = 1'b0;
    case (c)
      C_ADD:   e.r = x + y;
      C_SUB:   e.r = x - y;
      C_AND:   e.r = x & y;
      C_OR:    e.r = x | y;
      C_SLL:   e.r = x << y[5:0];
      default: begin e.r = 64'd0; e.il = 1'b1; end
    endcase
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      asserts++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done result=%h zero=%b illegal=%b", result, zero, illegal);
      end else begin
        sb_e = sb_q.pop_front();
        if ({result, zero, illegal} !== {sb_e.r, sb_e.z, sb_e.il}) begin
          failures++;
          $display("FAIL sb_result got r=%h z=%b il=%b exp r=%h z=%b il=%b",
                   result, zero, illegal, sb_e.r, sb_e.z, sb_e.il);
        end
      end
    end
  end

  // Drive one op at a negedge, return cycles until done and busy cycles seen.
  task automatic run_op(input logic [3:0] c, input logic [63:0] x, input logic [63:0] y,
                        output int lat, output int bc);
    sb_q.push_back(model(c, x, y));
    alu_ctrl = c; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    asserts++;
    if ({result, zero, busy, done, illegal} !== 68'd0) begin
      failures++;
      $display("FAIL reset_outputs got r=%h z=%b busy=%b done=%b il=%b exp all 0",
               result, zero, busy, done, illegal);
    end
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(C_ADD, 64'd5, 64'd7, lat, bc);
    asserts++;
    if (lat !== 0) begin failures++; $display("FAIL add_latency got %0d exp 0", lat); end
    asserts++;
    if (bc !== 0 || busy !== 1'b0) begin failures++; $display("FAIL add_busy got %0d exp 0", bc); end
  endtask

  task automatic test_sub();
    int lat, bc;
    run_op(C_SUB, 64'd7, 64'd7, lat, bc);
    asserts++;
    if (lat !== 0) begin failures++; $display("FAIL sub_eq_latency got %0d exp 0", lat); end
    run_op(C_SUB, 64'd0, 64'd1, lat, bc);
    asserts++;
    if (lat !== 0) begin failures++; $display("FAIL sub_wrap_latency got %0d exp 0", lat); end
  endtask

  task automatic test_sll();
    int lat, bc;
    repeat (2) @(negedge clk);
    run_op(C_SLL, 64'd1, 64'd3, lat, bc);
    asserts++;
    if (lat !== 3 || bc !== 3) begin
      failures++; $display("FAIL sll3_timing got lat=%0d busy=%0d exp 3/3", lat, bc);
    end
    run_op(C_SLL, 64'd1, 64'd63, lat, bc);
    asserts++;
    if (lat !== 63 || bc !== 63) begin
      failures++; $display("FAIL sll63_timing got lat=%0d busy=%0d exp 63/63", lat, bc);
    end
    // upper bits of b must not affect the shift amount (0x42 -> shamt 2)
    run_op(C_SLL, 64'hF000_0000_0000_0003, 64'h42, lat, bc);
    asserts++;
    if (lat !== 2 || bc !== 2) begin
      failures++; $display("FAIL sll_upper_b_timing got lat=%0d busy=%0d exp 2/2", lat, bc);
    end
    // shamt 0 (b = 64) behaves like a one-cycle op returning a
    run_op(C_SLL, 64'd5, 64'd64, lat, bc);
    asserts++;
    if (lat !== 0 || bc !== 0) begin
      failures++; $display("FAIL sll0_timing got lat=%0d busy=%0d exp 0/0", lat, bc);
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    int lat, bc;
    repeat (2) @(negedge clk);
    sb_q.push_back(model(C_SLL, 64'h1234_5678_9ABC_DEF1, 64'd10));
    alu_ctrl = C_SLL; a = 64'h1234_5678_9ABC_DEF1; b = 64'd10; start = 1'b1;
    @(negedge clk);                         // after edge k
    start = 1'b0;
    lat = 1;
    @(negedge clk);                         // after k+1
    lat++;
    // start sampled at edge k+3 while shifting: must be ignored
    alu_ctrl = C_ADD; a = 64'd1; b = 64'd2; start = 1'b1;
    @(negedge clk);                         // after k+2 -> edge k+3 next
    lat++;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    asserts++;
    if (lat !== 10) begin failures++; $display("FAIL ignore_latency got %0d exp 10", lat); end
    // start asserted in the done cycle is accepted immediately
    run_op(C_ADD, 64'd3, 64'd4, lat, bc);
    asserts++;
    if (lat !== 0) begin failures++; $display("FAIL back_to_back_latency got %0d exp 0", lat); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones;
    @(negedge clk);
    alu_ctrl = C_SLL; a = 64'd3; b = 64'd20; start = 1'b1;
    @(negedge clk);                         // after edge k
    start = 1'b0;
    @(negedge clk);                         // after k+1
    asserts++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got %b exp 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);                         // after k+2
    asserts++;
    if ({result, zero, busy, done, illegal} !== 68'd0) begin
      failures++;
      $display("FAIL abort_outputs got r=%h z=%b busy=%b done=%b il=%b exp all 0",
               result, zero, busy, done, illegal);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    asserts++;
    if (dones !== 0) begin failures++; $display("FAIL abort_no_done got %0d exp 0", dones); end
    run_op(C_AND, 64'h0F, 64'hFF, lat, bc);
    asserts++;
    if (lat !== 0) begin failures++; $display("FAIL and_latency got %0d exp 0", lat); end
    run_op(C_OR, 64'hF0, 64'h0F, lat, bc);
    asserts++;
    if (lat !== 0) begin failures++; $display("FAIL or_latency got %0d exp 0", lat); end
  endtask

  task automatic test_illegal();
    int lat, bc;
    @(negedge clk);
    run_op(4'b1111, 64'd5, 64'd7, lat, bc);
    asserts++;
    if (lat !== 0) begin failures++; $display("FAIL illegal_latency got %0d exp 0", lat); end
    @(negedge clk);
    // after the pulse, outputs hold in IDLE
    asserts++;
    if ({done, illegal, zero, result} !== {1'b0, 1'b1, 1'b1, 64'd0}) begin
      failures++;
      $display("FAIL illegal_hold got done=%b il=%b z=%b r=%h exp 0/1/1/0", done, illegal, zero, result);
    end
    run_op(C_ADD, 64'd1, 64'd1, lat, bc);
    run_op(4'b0011, 64'd9, 64'd9, lat, bc);
    run_op(C_SLL, 64'd1, 64'd1, lat, bc);
    asserts++;
    if (lat !== 1) begin failures++; $display("FAIL illegal_then_sll_latency got %0d exp 1", lat); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_ctrl = 4'd0; a = 64'd0; b = 64'd0;
    asserts = 0; failures = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_add();
    test_sub();
    test_sll();
    test_ignore_and_back_to_back();
    test_reset_abort();
    test_illegal();
    repeat (3) @(negedge clk);
    asserts++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_outstanding got %0d exp 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
